// File: rtl/instruction_fetch_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
//   imem_req_valid  fetch request presented (fetch -> memory)
//   imem_req_addr   word-aligned fetch address (fetch -> memory)
//   imem_req_ready  memory accepts the request (memory -> fetch)
//   imem_resp_valid response for the oldest accepted request, one cycle (memory -> fetch)
//   imem_resp_data  instruction word (memory -> fetch)
interface instruction_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one word fetch at a time, forwards the
// returned instruction to decode through an output register backed by a
// one-entry skid buffer, and restarts from a redirect target on request.
//   clk             clock, all state on the rising edge
//   rst             synchronous active-high reset
//   imem            instruction memory bus (master side)
//   redirect_valid  one-cycle branch/jump redirect from execute
//   redirect_pc     redirect target
//   id_valid        instruction presented to decode
//   id_instr        instruction word
//   id_pc           PC of id_instr
//   id_ready        decode consumes the instruction
//   misalign_fault  sticky, set by a redirect target with bits [1:0] != 0
//
// state  | meaning
// S_REQ  | no request outstanding; may issue a fetch
// S_WAIT | one request outstanding, its response will be kept
// S_KILL | one request outstanding, its response will be dropped
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_if.master        imem,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [31:0]                id_pc,
  input  logic                       id_ready,
  output logic                       misalign_fault
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_KILL
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        req_fire;
  logic        resp_take;
  logic        out_free;

  // Address comes straight from the pc register, never from inputs.
  assign imem.imem_req_addr = pc;

  assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
  assign out_free = !id_valid || id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    imem.imem_req_valid = 1'b0;
    resp_take           = 1'b0;

    case (state)
      S_REQ: begin
        // Stall issue while the skid entry is occupied so a response always
        // has somewhere to land.
        imem.imem_req_valid = !rst && !skid_valid && !redirect_valid;
        if (imem.imem_req_valid && imem.imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_resp_valid) begin
          resp_take = !redirect_valid;
          state_nxt = S_REQ;
        end
      end
      S_KILL: begin
        if (imem.imem_resp_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase

    // A response arriving in the redirect cycle answers the outstanding
    // request, so there is nothing left to kill.
    if (redirect_valid) begin
      if ((state == S_WAIT || state == S_KILL) && !imem.imem_resp_valid) begin
        state_nxt = S_KILL;
      end else begin
        state_nxt = S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      req_pc         <= RESET_PC;
      id_valid       <= 1'b0;
      id_instr       <= 32'h0;
      id_pc          <= 32'h0;
      skid_valid     <= 1'b0;
      skid_instr     <= 32'h0;
      skid_pc        <= 32'h0;
      misalign_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= {redirect_pc[31:2], 2'b00};
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_fault <= 1'b1;
      end
    end else begin
      if (req_fire) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end

      if (out_free) begin
        if (skid_valid) begin
          // Older skid entry goes first; a same-cycle response refills it.
          id_valid   <= 1'b1;
          id_instr   <= skid_instr;
          id_pc      <= skid_pc;
          skid_valid <= resp_take;
          if (resp_take) begin
            skid_instr <= imem.imem_resp_data;
            skid_pc    <= req_pc;
          end
        end else if (resp_take) begin
          id_valid <= 1'b1;
          id_instr <= imem.imem_resp_data;
          id_pc    <= req_pc;
        end else begin
          id_valid <= 1'b0;
        end
      end else if (resp_take) begin
        skid_valid <= 1'b1;
        skid_instr <= imem.imem_resp_data;
        skid_pc    <= req_pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random traffic.
// A negedge monitor keeps a fetch-stream reference model (next pc, one
// outstanding request, kill-on-redirect, ordered delivery queue) and compares
// every decode handshake and memory request against it.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;
  logic        misalign_fault;

  instruction_fetch_if imem_bus ();

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  exp_t        sbq[$];
  mreq_t       mem_q[$];
  logic [31:0] dq[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_req_addr = 32'h0;
  logic        m_out = 1'b0;
  logic        m_kill = 1'b0;
  logic        m_fault = 1'b0;
  logic [31:0] m_prev_addr = 32'h0;
  logic        wrap_seen = 1'b0;
  int          req_cnt = 0;
  int          n_deliv = 0;
  int unsigned cyc = 0;
  int unsigned lat_fixed = 1;
  logic        inject_stray = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h0020_81B3;
      default:       return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endcase
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL timeout %s: event not seen within bound", name);
  endtask

  // instruction memory: answers each accepted request after its latency
  always @(posedge clk) begin : memory
    mreq_t m;
    cyc++;
    #1;
    imem_bus.imem_resp_valid = 1'b0;
    imem_bus.imem_resp_data  = $urandom();
    if (inject_stray) begin
      imem_bus.imem_resp_valid = 1'b1;
      imem_bus.imem_resp_data  = 32'hDEAD_BEEF;
      inject_stray = 1'b0;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_bus.imem_resp_valid = 1'b1;
      imem_bus.imem_resp_data  = mem_word(m.addr);
    end
  end

  // monitor + reference model, evaluated for the edge that ends this cycle
  always @(negedge clk) begin : monitor
    logic        hs_req;
    logic [31:0] pc_before;
    int unsigned lat;
    exp_t        e;
    chk1("id_valid", id_valid, sbq.size() != 0);
    chk1("misalign_fault", misalign_fault, m_fault);
    if (rst) begin
      chk1("req_in_reset", imem_bus.imem_req_valid, 1'b0);
      sbq.delete();
      mem_q.delete();
      m_pc    = RESET_PC;
      m_out   = 1'b0;
      m_kill  = 1'b0;
      m_fault = 1'b0;
    end else begin
      hs_req    = imem_bus.imem_req_valid && imem_bus.imem_req_ready;
      pc_before = m_pc;
      if (id_valid && id_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_instr: actual pc=%h expected none", id_pc);
        end else begin
          e = sbq.pop_front();
          chk32("id_pc", id_pc, e.pc);
          chk32("id_instr", id_instr, e.instr);
        end
        dq.push_back(id_pc);
        n_deliv++;
      end
      if (hs_req) begin
        chk32("req_addr", imem_bus.imem_req_addr, pc_before);
        chk1("req_legal", !(m_out || redirect_valid), 1'b1);
        if (m_prev_addr == 32'hFFFF_FFFC && imem_bus.imem_req_addr == 32'h0) wrap_seen = 1'b1;
        m_prev_addr = imem_bus.imem_req_addr;
      end
      if (redirect_valid) begin
        sbq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
        if (m_out) begin
          if (imem_bus.imem_resp_valid) begin
            m_out  = 1'b0;
            m_kill = 1'b0;
          end else begin
            m_kill = 1'b1;
          end
        end
      end else if (imem_bus.imem_resp_valid && m_out) begin
        if (!m_kill) sbq.push_back('{pc: m_req_addr, instr: mem_word(m_req_addr)});
        m_out  = 1'b0;
        m_kill = 1'b0;
      end
      if (hs_req) begin
        lat = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 3);
        mem_q.push_back('{addr: pc_before, due: cyc + lat});
        m_req_addr = pc_before;
        m_pc       = pc_before + 32'd4;
        m_out      = 1'b1;
        req_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int  r0;
    int  d0;
    logic found;
    imem_bus.imem_req_ready = 1'b0;

    // in-order fetch of 0,4,8 and one instruction per two cycles
    lat_fixed = 1;
    do_reset();
    chk1("reset_id_valid", id_valid, 1'b0);
    chk32("reset_id_pc", id_pc, 32'h0);
    chk32("reset_id_instr", id_instr, 32'h0);
    imem_bus.imem_req_ready = 1'b1;
    id_ready = 1'b1;
    dq.delete();
    repeat (10) step();
    d0 = n_deliv;
    repeat (20) step();
    chk32("throughput", 32'(n_deliv - d0), 32'd10);
    chk1("first3_count", dq.size() >= 3, 1'b1);
    if (dq.size() >= 3) begin
      chk32("first_pc0", dq[0], 32'h0);
      chk32("first_pc1", dq[1], 32'h4);
      chk32("first_pc2", dq[2], 32'h8);
    end

    // decode stall: output + skid full, no further request
    do_reset();
    id_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (id_valid) found = 1'b1;
    end
    if (!found) timeout("first_instr");
    id_ready = 1'b0;
    r0 = req_cnt;
    repeat (6) step();
    chk32("stall_req_count", 32'(req_cnt - r0), 32'd1);
    chk1("stall_id_valid", id_valid, 1'b1);
    chk32("stall_id_pc", id_pc, 32'h0);
    dq.delete();
    id_ready = 1'b1;
    repeat (10) step();
    chk1("release_count", dq.size() >= 3, 1'b1);
    if (dq.size() >= 3) begin
      chk32("release_pc0", dq[0], 32'h0);
      chk32("release_pc1", dq[1], 32'h4);
      chk32("release_pc2", dq[2], 32'h8);
    end

    // redirect while the request at 8 is outstanding
    lat_fixed = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_out && m_req_addr == 32'h8) found = 1'b1;
    end
    if (!found) timeout("req_at_8");
    pulse_redirect(32'h0000_0100);
    dq.delete();
    repeat (15) step();
    chk1("kill_count", dq.size() >= 1, 1'b1);
    if (dq.size() >= 1) chk32("kill_next_pc", dq[0], 32'h100);

    // redirect coinciding with a response
    lat_fixed = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (imem_bus.imem_resp_valid && m_out && m_req_addr == 32'h4) found = 1'b1;
    end
    if (!found) timeout("resp_at_4");
    pulse_redirect(32'h0000_0200);
    chk1("redir_resp_id_valid", id_valid, 1'b0);
    dq.delete();
    repeat (12) step();
    chk1("redir_resp_count", dq.size() >= 1, 1'b1);
    if (dq.size() >= 1) chk32("redir_resp_pc", dq[0], 32'h200);

    // misaligned redirect: sticky fault, aligned target
    step();
    pulse_redirect(32'h0000_0102);
    dq.delete();
    repeat (12) step();
    chk1("misalign_set", misalign_fault, 1'b1);
    chk1("misalign_count", dq.size() >= 1, 1'b1);
    if (dq.size() >= 1) chk32("misalign_pc", dq[0], 32'h100);
    pulse_redirect(32'h0000_0040);
    repeat (5) step();
    chk1("misalign_sticky", misalign_fault, 1'b1);
    do_reset();
    chk1("misalign_cleared", misalign_fault, 1'b0);

    // address wrap at the top of memory
    wrap_seen = 1'b0;
    pulse_redirect(32'hFFFF_FFF8);
    dq.delete();
    repeat (15) step();
    chk1("wrap_seen", wrap_seen, 1'b1);
    chk1("wrap_count", dq.size() >= 3, 1'b1);
    if (dq.size() >= 3) begin
      chk32("wrap_pc0", dq[0], 32'hFFFF_FFF8);
      chk32("wrap_pc1", dq[1], 32'hFFFF_FFFC);
      chk32("wrap_pc2", dq[2], 32'h0);
    end

    // stray response right after reset is ignored
    imem_bus.imem_req_ready = 1'b0;
    do_reset();
    inject_stray = 1'b1;
    step();
    step();
    chk1("stray_id_valid", id_valid, 1'b0);
    imem_bus.imem_req_ready = 1'b1;
    dq.delete();
    repeat (8) step();
    chk1("stray_count", dq.size() >= 1, 1'b1);
    if (dq.size() >= 1) chk32("stray_resume_pc", dq[0], RESET_PC);

    // random traffic
    lat_fixed = 0;
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      imem_bus.imem_req_ready = ($urandom_range(0, 9) < 7);
      id_ready       = ($urandom_range(0, 9) < 7);
      rst            = ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_pc = $urandom();
        1:       redirect_pc = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
        default: redirect_pc = $urandom() & 32'h0000_FFFC;
      endcase
      step();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    imem_bus.imem_req_ready = 1'b1;
    id_ready = 1'b1;
    repeat (10) step();
    chk1("random_progress", (n_deliv - d0) > 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
